// File: rtl/conv_pkg.sv
// Shared definitions for the parameterised convolution block: one-hot FSM
// encodings and the accumulator sizing rule.
package conv_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_MAC  = 4'b0010,
      ST_BIAS = 4'b0100,
      ST_OUT  = 4'b1000
   } state_e;

   // Wide enough for K*K*CIN full-scale products plus sign, so it never wraps.
   function automatic int acc_width(input int dw, input int k, input int cin);
      return 2 * dw + $clog2(k * k * cin) + 1;
   endfunction

endpackage

// File: rtl/conv_row_mac.sv
// Combinational signed dot product of one kernel row: sum of K x*w products.
module conv_row_mac
   import conv_pkg::*;
#(
   parameter int DW    = 9,
   parameter int K     = 5,
   parameter int OUT_W = 2 * DW + 4
) (
   input  logic        [K*DW-1:0]  x_row,
   input  logic        [K*DW-1:0]  w_row,
   output logic signed [OUT_W-1:0] row_sum
);

   logic signed [OUT_W-1:0] x_ext [K];
   logic signed [OUT_W-1:0] w_ext [K];
   logic signed [OUT_W-1:0] prod  [K];

   // Operands are widened first so each product is formed at full precision.
   for (genvar j = 0; j < K; j++) begin : g_tap
      assign x_ext[j] = OUT_W'(signed'(x_row[j*DW +: DW]));
      assign w_ext[j] = OUT_W'(signed'(w_row[j*DW +: DW]));
      assign prod[j]  = x_ext[j] * w_ext[j];
   end

   always_comb begin
      row_sum = '0;
      for (int j = 0; j < K; j++) begin
         row_sum = row_sum + prod[j];
      end
   end

endmodule

// File: rtl/conv_param.sv
// KxK x CIN convolution: accumulates row beats, adds bias, scales, applies
// optional ReLU, saturates, and holds the result until the consumer takes it.
module conv_param
   import conv_pkg::*;
#(
   parameter int DW   = 9,
   parameter int K    = 5,
   parameter int CIN  = 1,
   parameter int FRAC = 0
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 x_valid,
   output logic                 x_ready,
   input  logic [K*DW-1:0]      x_row,
   input  logic [K*DW-1:0]      w_row,
   input  logic signed [DW-1:0] bias,
   input  logic                 relu_en,
   output logic                 conv_valid,
   input  logic                 conv_ready,
   output logic signed [DW-1:0] conv_data
);

   localparam int ACC_W = acc_width(DW, K, CIN);
   localparam int BEATS = K * CIN;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam int SUM_W = ACC_W + FRAC + 1;

   localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'(2 ** (DW - 1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN   = SUM_W'(-(2 ** (DW - 1)));

   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [DW-1:0]    data_q, data_d;
   logic signed [DW-1:0]    bias_q, bias_d;
   logic                    relu_q, relu_d;

   logic signed [ACC_W-1:0] row_sum;
   logic signed [SUM_W-1:0] biased;
   logic signed [SUM_W-1:0] scaled;
   logic                    accept;

   conv_row_mac #(
      .DW    (DW),
      .K     (K),
      .OUT_W (ACC_W)
   ) u_row_mac (
      .x_row   (x_row),
      .w_row   (w_row),
      .row_sum (row_sum)
   );

   assign x_ready    = (state_q == ST_IDLE) || (state_q == ST_MAC);
   assign conv_valid = (state_q == ST_OUT);
   assign conv_data  = data_q;
   assign accept     = x_valid && x_ready;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      bias_d  = bias_q;
      relu_d  = relu_q;
      biased  = '0;
      scaled  = '0;

      case (state_q)
         ST_IDLE, ST_MAC: begin
            if (accept) begin
               acc_d = acc_q + row_sum;
               if (cnt_q == LAST_BEAT) begin
                  state_d = ST_BIAS;
                  bias_d  = bias;
                  relu_d  = relu_en;
               end else begin
                  state_d = ST_MAC;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_BIAS: begin
            // Bias is aligned to the accumulator's fixed point before the floor shift.
            biased = SUM_W'(acc_q) + (SUM_W'(bias_q) <<< FRAC);
            scaled = biased >>> FRAC;
            if (relu_q && scaled[SUM_W-1]) begin
               scaled = '0;
            end
            if (scaled > SAT_MAX) begin
               data_d = SAT_MAX[DW-1:0];
            end else if (scaled < SAT_MIN) begin
               data_d = SAT_MIN[DW-1:0];
            end else begin
               data_d = scaled[DW-1:0];
            end
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (conv_ready) begin
               state_d = ST_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         bias_q  <= '0;
         relu_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         bias_q  <= bias_d;
         relu_q  <= relu_d;
      end
   end

endmodule

// File: tb/tb_conv_param.sv
// Directed bench for conv_param: table of uniform-tap frames checked on a
// FRAC=0 and a FRAC=4 instance, plus gap, back-pressure and reset sequences.
module tb_conv_param;

   localparam int DW = 9;
   localparam int K  = 5;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 x_valid;
   logic [K*DW-1:0]      x_row;
   logic [K*DW-1:0]      w_row;
   logic signed [DW-1:0] bias;
   logic                 relu_en;
   logic                 conv_ready;

   logic                 x_ready, conv_valid;
   logic signed [DW-1:0] conv_data;
   logic                 x_ready4, conv_valid4;
   logic signed [DW-1:0] conv_data4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_param #(.DW(DW), .K(K), .CIN(1), .FRAC(0)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .x_valid    (x_valid),
      .x_ready    (x_ready),
      .x_row      (x_row),
      .w_row      (w_row),
      .bias       (bias),
      .relu_en    (relu_en),
      .conv_valid (conv_valid),
      .conv_ready (conv_ready),
      .conv_data  (conv_data)
   );

   conv_param #(.DW(DW), .K(K), .CIN(1), .FRAC(4)) u_dut4 (
      .clk        (clk),
      .rstn       (rstn),
      .x_valid    (x_valid),
      .x_ready    (x_ready4),
      .x_row      (x_row),
      .w_row      (w_row),
      .bias       (bias),
      .relu_en    (relu_en),
      .conv_valid (conv_valid4),
      .conv_ready (conv_ready),
      .conv_data  (conv_data4)
   );

   typedef struct {
      int x;
      int w;
      int b;
      bit relu;
      int exp0;
      int exp4;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One row beat, all K taps equal; waits for the accepting edge.
   task automatic beat(input int xv, input int wv, input int bv, input bit rv);
      logic signed [DW-1:0] xs, ws;
      xs = DW'(xv);
      ws = DW'(wv);
      @(negedge clk);
      x_valid = 1'b1;
      x_row   = {K{xs}};
      w_row   = {K{ws}};
      bias    = DW'(bv);
      relu_en = rv;
      check("x_ready_on_beat", int'(x_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      x_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Called right after the last accepting edge: checks latency and result, then takes it.
   task automatic finish_frame(input string name, input int exp0, input int exp4, input bit chk4);
      check({name, "_bias_valid"}, int'(conv_valid), 0);
      check({name, "_bias_ready"}, int'(x_ready), 0);
      @(negedge clk);
      x_valid = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_valid"}, int'(conv_valid), 1);
      check({name, "_data"}, int'(conv_data), exp0);
      if (chk4) begin
         check({name, "_data_frac4"}, int'(conv_data4), exp4);
      end
      @(negedge clk);
      conv_ready = 1'b1;
      @(posedge clk);
      #1;
      check({name, "_done_valid"}, int'(conv_valid), 0);
      check({name, "_done_ready"}, int'(x_ready), 1);
      @(negedge clk);
      conv_ready = 1'b0;
   endtask

   initial begin
      // acc = 25*x*w; FRAC=4 result is floor((acc + b*16)/16), then relu/saturate.
      vecs[0] = '{x:    1, w:   1, b: 0, relu: 1'b0, exp0:   25, exp4:    1};
      vecs[1] = '{x:  100, w: 100, b: 0, relu: 1'b0, exp0:  255, exp4:  255};
      vecs[2] = '{x:   -1, w:   1, b: 0, relu: 1'b0, exp0:  -25, exp4:   -2};
      vecs[3] = '{x:   -1, w:   1, b: 0, relu: 1'b1, exp0:    0, exp4:    0};
      vecs[4] = '{x: -100, w: 100, b: 0, relu: 1'b0, exp0: -256, exp4: -256};
      vecs[5] = '{x:    2, w:   3, b: 5, relu: 1'b0, exp0:  155, exp4:   14};
      vecs[6] = '{x:    4, w:   4, b: 2, relu: 1'b0, exp0:  255, exp4:   27};

      rstn       = 1'b0;
      x_valid    = 1'b0;
      x_row      = '0;
      w_row      = '0;
      bias       = '0;
      relu_en    = 1'b0;
      conv_ready = 1'b0;
      #12;
      check("reset_valid", int'(conv_valid), 0);
      check("reset_data", int'(conv_data), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_ready", int'(x_ready), 1);

      foreach (vecs[i]) begin
         for (int b = 0; b < K; b++) begin
            beat(vecs[i].x, vecs[i].w, vecs[i].b, vecs[i].relu);
         end
         finish_frame($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp4, 1'b1);
      end

      // Gaps between beats, then back-pressure with junk beats offered during OUT.
      for (int b = 0; b < K; b++) begin
         beat(1, 1, 0, 1'b0);
         if (b < K - 1) begin
            idle_cycle();
            idle_cycle();
            check("gap_no_valid", int'(conv_valid), 0);
         end
      end
      check("gap_bias_valid", int'(conv_valid), 0);
      @(negedge clk);
      x_valid = 1'b1;
      x_row   = {K{9'sd50}};
      w_row   = {K{9'sd50}};
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         check("hold_valid", int'(conv_valid), 1);
         check("hold_data", int'(conv_data), 25);
         check("hold_ready", int'(x_ready), 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      x_valid    = 1'b0;
      conv_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold_release", int'(conv_valid), 0);
      @(negedge clk);
      conv_ready = 1'b0;
      for (int b = 0; b < K; b++) begin
         beat(1, 1, 0, 1'b0);
      end
      finish_frame("after_ignored", 25, 1, 1'b1);

      // Reset after three beats discards the partial frame.
      for (int b = 0; b < 3; b++) begin
         beat(1, 1, 0, 1'b0);
      end
      @(negedge clk);
      x_valid = 1'b0;
      rstn    = 1'b0;
      #1;
      check("midrst_valid", int'(conv_valid), 0);
      check("midrst_data", int'(conv_data), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ready", int'(x_ready), 1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check("midrst_no_spurious", int'(conv_valid), 0);
      end
      for (int b = 0; b < K; b++) begin
         beat(1, 1, 0, 1'b0);
      end
      finish_frame("midrst_frame", 25, 1, 1'b0);

      // Reset while the result is waiting in OUT.
      for (int b = 0; b < K; b++) begin
         beat(-1, 1, 0, 1'b0);
      end
      @(negedge clk);
      x_valid = 1'b0;
      @(posedge clk);
      #1;
      check("outrst_pre_valid", int'(conv_valid), 1);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("outrst_valid", int'(conv_valid), 0);
      check("outrst_data", int'(conv_data), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("outrst_ready", int'(x_ready), 1);
      for (int b = 0; b < K; b++) begin
         beat(2, 3, 5, 1'b0);
      end
      finish_frame("outrst_frame", 155, 14, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
